flag_issue_sched: RTL

- Single-slot issue scheduler between decode and execute.
- Owns the architectural flag register (Z,C,N,V) and counts in-flight flag-setting instructions.
- Holds a conditional instruction until its flags are resolved, then evaluates its 4-bit condition code and issues it as execute or squash.

---
 rtl/flag_issue_sched_pkg.sv | 25 ++
 rtl/flag_issue_sched_if.sv | 26 ++
 rtl/flag_pending_ctr.sv | 33 +++
 rtl/flag_issue_sched.sv | 130 +++++++++++++
 4 files changed

// File: rtl/flag_issue_sched_pkg.sv
// Shared constants for the flag issue scheduler: flag bit positions,
// condition classes and FSM state encoding.
package flag_issue_sched_pkg;

    typedef logic [3:0] flags_t;

    localparam int FLAG_Z = 0;
    localparam int FLAG_C = 1;
    localparam int FLAG_N = 2;
    localparam int FLAG_V = 3;

    localparam logic [2:0] CLS_Z  = 3'b000;
    localparam logic [2:0] CLS_C  = 3'b001;
    localparam logic [2:0] CLS_N  = 3'b010;
    localparam logic [2:0] CLS_V  = 3'b011;
    localparam logic [2:0] CLS_HI = 3'b100;
    localparam logic [2:0] CLS_GE = 3'b101;
    localparam logic [2:0] CLS_GT = 3'b110;
    localparam logic [2:0] CLS_AL = 3'b111;

    localparam logic [1:0] ST_EMPTY = 2'd0;
    localparam logic [1:0] ST_WAIT  = 2'd1;
    localparam logic [1:0] ST_OUT   = 2'd2;

endpackage

// File: rtl/flag_issue_sched_if.sv
// Decode-side and execute-side handshakes of the issue scheduler.
// master = decode/execute pipeline, slave = scheduler.
interface flag_issue_sched_if #(
    parameter int TAG_W = 8
);
    logic             in_valid;
    logic             in_ready;
    logic [3:0]       in_cond;
    logic             in_setflags;
    logic [TAG_W-1:0] in_tag;
    logic             out_valid;
    logic             out_ready;
    logic             out_exec;
    logic             out_setflags;
    logic [TAG_W-1:0] out_tag;

    modport master (
        output in_valid, in_cond, in_setflags, in_tag, out_ready,
        input  in_ready, out_valid, out_exec, out_setflags, out_tag
    );

    modport slave (
        input  in_valid, in_cond, in_setflags, in_tag, out_ready,
        output in_ready, out_valid, out_exec, out_setflags, out_tag
    );
endinterface

// File: rtl/flag_pending_ctr.sv
// Saturating up/down counter of in-flight flag-setting instructions.
// Simultaneous inc and dec leave the count unchanged; clear wins over both.
module flag_pending_ctr #(
    parameter int MAX = 3,
    localparam int W = $clog2(MAX + 1)
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         inc,
    input  logic         dec,
    input  logic         clear,
    output logic [W-1:0] count,
    output logic         full
);
    localparam logic [W-1:0] MAX_CNT = W'(MAX);

    logic [W-1:0] count_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            count_reg <= '0;
        end else if (clear) begin
            count_reg <= '0;
        end else if (inc && !dec && count_reg != MAX_CNT) begin
            count_reg <= count_reg + W'(1);
        end else if (dec && !inc && count_reg != '0) begin
            count_reg <= count_reg - W'(1);
        end
    end

    assign count = count_reg;
    assign full  = (count_reg == MAX_CNT);
endmodule

// File: rtl/flag_issue_sched.sv
// Single-slot issue scheduler: holds a conditional instruction until its flags
// resolve, then issues it as execute/squash. FLAG_BYPASS_EN resolves in the wb cycle.
module flag_issue_sched
    import flag_issue_sched_pkg::*;
#(
    parameter int MAX_PENDING = 3,
    parameter int TAG_W       = 8,
    localparam int PCW = $clog2(MAX_PENDING + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    flag_issue_sched_if.slave    io,
    input  logic                 wb_valid,
    input  logic [3:0]           wb_flags,
    input  logic                 flush,
    output logic [3:0]           cpsr_out,
    output logic [PCW-1:0]       pending_out
);

    function automatic logic cond_eval(input logic [3:0] cond, input flags_t f);
        logic base;
        base = 1'b0;
        case (cond[3:1])
            CLS_Z:   base = f[FLAG_Z];
            CLS_C:   base = f[FLAG_C];
            CLS_N:   base = f[FLAG_N];
            CLS_V:   base = f[FLAG_V];
            CLS_HI:  base = f[FLAG_C] & ~f[FLAG_Z];
            CLS_GE:  base = ~(f[FLAG_N] ^ f[FLAG_V]);
            CLS_GT:  base = ~f[FLAG_Z] & ~(f[FLAG_N] ^ f[FLAG_V]);
            default: base = 1'b0;
        endcase
        return (cond[3:1] == CLS_AL) ? 1'b1 : (base ^ cond[0]);
    endfunction

    logic [1:0]       state_reg, state_next;
    logic [3:0]       cond_reg, cond_next;
    logic             setflags_reg, setflags_next;
    logic [TAG_W-1:0] tag_reg, tag_next;
    logic             exec_reg, exec_next;
    flags_t           cpsr_reg;
    logic [PCW-1:0]   pending;
    logic             full;
    logic             dec, inc, stall, out_valid_w, handshake, accept;
    logic [PCW:0]     pend_eff;
    flags_t           flags_eff;

    assign dec         = wb_valid & (pending != '0);
    assign stall       = exec_reg & setflags_reg & full & ~dec;
    assign out_valid_w = (state_reg == ST_OUT) & ~stall & ~flush;
    assign handshake   = out_valid_w & io.out_ready;
    assign inc         = handshake & exec_reg & setflags_reg;
    // A stalled slot still holds its instruction, so only a real handshake frees it.
    assign io.in_ready = ~flush & ((state_reg == ST_EMPTY) | handshake);
    assign accept      = io.in_valid & io.in_ready;

`ifdef FLAG_BYPASS_EN
    assign pend_eff  = {1'b0, pending} + {{PCW{1'b0}}, inc} - {{PCW{1'b0}}, dec};
    assign flags_eff = wb_valid ? wb_flags : cpsr_reg;
`else
    assign pend_eff  = {1'b0, pending} + {{PCW{1'b0}}, inc};
    assign flags_eff = cpsr_reg;
`endif

    always_comb begin
        state_next    = state_reg;
        cond_next     = cond_reg;
        setflags_next = setflags_reg;
        tag_next      = tag_reg;
        exec_next     = exec_reg;
        if (flush) begin
            state_next = ST_EMPTY;
        end else if (accept) begin
            cond_next     = io.in_cond;
            setflags_next = io.in_setflags;
            tag_next      = io.in_tag;
            if (io.in_cond[3:1] == CLS_AL || pend_eff == '0) begin
                state_next = ST_OUT;
                exec_next  = cond_eval(io.in_cond, flags_eff);
            end else begin
                state_next = ST_WAIT;
            end
        end else if (handshake) begin
            state_next = ST_EMPTY;
        end else if (state_reg == ST_WAIT && pend_eff == '0) begin
            state_next = ST_OUT;
            exec_next  = cond_eval(cond_reg, flags_eff);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg    <= ST_EMPTY;
            cond_reg     <= '0;
            setflags_reg <= 1'b0;
            tag_reg      <= '0;
            exec_reg     <= 1'b0;
            cpsr_reg     <= '0;
        end else begin
            state_reg    <= state_next;
            cond_reg     <= cond_next;
            setflags_reg <= setflags_next;
            tag_reg      <= tag_next;
            exec_reg     <= exec_next;
            if (wb_valid) begin
                cpsr_reg <= wb_flags;
            end
        end
    end

    flag_pending_ctr #(
        .MAX(MAX_PENDING)
    ) u_pending_ctr (
        .clk  (clk),
        .rst_n(rst_n),
        .inc  (inc),
        .dec  (dec),
        .clear(flush),
        .count(pending),
        .full (full)
    );

    assign io.out_valid    = out_valid_w;
    assign io.out_exec     = exec_reg;
    assign io.out_setflags = setflags_reg;
    assign io.out_tag      = tag_reg;
    assign cpsr_out        = cpsr_reg;
    assign pending_out     = pending;

endmodule
